// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared opcode constants, FSM states and helpers for alu_mc
//
// Purpose: common definitions imported by alu_mc and alu_mc_muldiv.
// Contents: 6-bit opcode set, top FSM state encoding, iterative-unit
//           operation select, and a predicate that picks out the
//           multi-cycle opcodes.
package alu_mc_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD    = 6'h00;
  localparam logic [OP_W-1:0] OP_SUB    = 6'h01;
  localparam logic [OP_W-1:0] OP_AND    = 6'h02;
  localparam logic [OP_W-1:0] OP_OR     = 6'h03;
  localparam logic [OP_W-1:0] OP_XOR    = 6'h04;
  localparam logic [OP_W-1:0] OP_NOR    = 6'h05;
  localparam logic [OP_W-1:0] OP_SLL    = 6'h06;
  localparam logic [OP_W-1:0] OP_SRL    = 6'h07;
  localparam logic [OP_W-1:0] OP_SRA    = 6'h08;
  localparam logic [OP_W-1:0] OP_MOV_A  = 6'h09;
  localparam logic [OP_W-1:0] OP_MOV_B  = 6'h0A;
  localparam logic [OP_W-1:0] OP_MUL    = 6'h0B;
  localparam logic [OP_W-1:0] OP_DIV    = 6'h0C;
  localparam logic [OP_W-1:0] OP_REMDER = 6'h0D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_e;

  function automatic logic is_iter(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REMDER);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// rtl/alu_mc_muldiv.sv - iterative shift-add multiplier and restoring divider
//
// Purpose: computes unsigned MUL (low half + high-half-nonzero flag),
//          DIV and REM in exactly WIDTH iterations after start.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             load operands (one-cycle pulse)
//   op                MD_MUL / MD_DIV / MD_REM
//   a, b              operands sampled on start
//   done              high during the cycle whose edge performs the last
//                     iteration; result/overflow are valid in that cycle
//   result, overflow  combinational view of the final iteration
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    count;
  md_op_e           op_q;
  logic [WIDTH-1:0] b_q;
  // Multiply: {partial high, multiplier low}. Divide: {remainder, quotient}.
  // Both start as {0, a}, so one register serves either unit.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;

  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                (acc[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial     = rem_shift - {1'b0, b_q};
    if (op_q == MD_MUL)
      acc_next = {add_sum, acc[WIDTH-1:1]};
    else if (trial[WIDTH])
      // Trial subtract went negative: restore, quotient bit 0.
      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  assign done = running && (count == CW'(WIDTH - 1));

  always_comb begin
    overflow = 1'b0;
    if (op_q == MD_MUL) begin
      result   = acc_next[WIDTH-1:0];
      overflow = |acc_next[2*WIDTH-1:WIDTH];
    end else if (b_q == '0) begin
      // Divide by zero still runs the full count; answer is forced.
      result = '1;
    end else if (op_q == MD_DIV) begin
      result = acc_next[WIDTH-1:0];
    end else begin
      result = acc_next[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
      op_q    <= MD_MUL;
      b_q     <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      op_q    <= op;
      b_q     <= b;
      acc     <= {{WIDTH{1'b0}}, a};
    end else if (running) begin
      acc   <= acc_next;
      count <= count + 1'b1;
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and result register
//
// Purpose: single-cycle ops complete at the accept edge; MUL/DIV/REM use
//          alu_mc_muldiv and complete WIDTH clocks later. Result, flags and
//          tag are held until the consumer takes them.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         operation handshake; in_op, in_a, in_b, in_tag
//   out_valid/out_ready       result handshake; out_result, out_tag
//   out_zero/negative/carry/overflow/illegal   result flags
//   busy                      iterative op in progress
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state;
  logic             accept;
  logic             iter_op;
  md_op_e           md_op;
  logic             md_done;
  logic             md_overflow;
  logic [WIDTH-1:0] md_result;
  logic [TAG_W-1:0] tag_q;

  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic             sc_overflow;
  logic             sc_illegal;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SH_W-1:0]  shamt;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign iter_op  = is_iter(in_op);

  always_comb begin
    md_op = MD_MUL;
    if (in_op == OP_DIV)
      md_op = MD_DIV;
    else if (in_op == OP_REMDER)
      md_op = MD_REM;
  end

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && iter_op),
    .op       (md_op),
    .a        (in_a),
    .b        (in_b),
    .done     (md_done),
    .result   (md_result),
    .overflow (md_overflow)
  );

  always_comb begin
    shamt       = in_b[SH_W-1:0];
    sum_ext     = {1'b0, in_a} + {1'b0, in_b};
    diff_ext    = {1'b0, in_a} - {1'b0, in_b};
    sc_result   = '0;
    sc_carry    = 1'b0;
    sc_overflow = 1'b0;
    sc_illegal  = 1'b0;
    case (in_op)
      OP_ADD: begin
        sc_result   = sum_ext[WIDTH-1:0];
        sc_carry    = sum_ext[WIDTH];
        sc_overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result   = diff_ext[WIDTH-1:0];
        sc_carry    = diff_ext[WIDTH];  // borrow: a < b unsigned
        sc_overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:   sc_result = in_a & in_b;
      OP_OR:    sc_result = in_a | in_b;
      OP_XOR:   sc_result = in_a ^ in_b;
      OP_NOR:   sc_result = ~(in_a | in_b);
      OP_SLL:   sc_result = in_a << shamt;
      OP_SRL:   sc_result = in_a >> shamt;
      OP_SRA:   sc_result = $signed(in_a) >>> shamt;
      OP_MOV_A: sc_result = in_a;
      OP_MOV_B: sc_result = in_b;
      OP_MUL, OP_DIV, OP_REMDER: sc_result = '0;  // handled by muldiv
      default:  sc_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      busy         <= 1'b0;
      tag_q        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (iter_op) begin
              state     <= ST_BUSY;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              tag_q     <= in_tag;
            end else begin
              state        <= ST_DONE;
              out_valid    <= 1'b1;
              out_result   <= sc_result;
              out_zero     <= (sc_result == '0);
              out_negative <= sc_result[WIDTH-1];
              out_carry    <= sc_carry;
              out_overflow <= sc_overflow;
              out_illegal  <= sc_illegal;
              out_tag      <= in_tag;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            out_valid    <= 1'b1;
            out_result   <= md_result;
            out_zero     <= (md_result == '0);
            out_negative <= md_result[WIDTH-1];
            out_carry    <= 1'b0;
            out_overflow <= md_overflow;
            out_illegal  <= 1'b0;
            out_tag      <= tag_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (WIDTH=32 and WIDTH=8 instances)
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid32, in_valid8, out_ready;
  logic [5:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;

  logic        rdy32, ov32, z32, n32, c32, v32, il32, busy32;
  logic [31:0] res32;
  logic [3:0]  tag32;
  logic        rdy8, ov8, z8, n8, c8, v8, il8, busy8;
  logic [7:0]  res8;
  logic [3:0]  tag8;

  alu_mc #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(rdy32), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_result(res32), .out_zero(z32), .out_negative(n32), .out_carry(c32),
    .out_overflow(v32), .out_illegal(il32), .out_tag(tag32), .busy(busy32)
  );

  alu_mc #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(rdy8), .in_op(in_op),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_tag(in_tag), .out_valid(ov8), .out_ready(out_ready),
    .out_result(res8), .out_zero(z8), .out_negative(n8), .out_carry(c8),
    .out_overflow(v8), .out_illegal(il8), .out_tag(tag8), .busy(busy8)
  );

  logic        sel8 = 1'b0;
  logic        o_rdy, o_valid, o_z, o_n, o_c, o_v, o_il, o_busy;
  logic [31:0] o_res;
  logic [3:0]  o_tag;

  always_comb begin
    if (sel8) begin
      o_rdy = rdy8; o_valid = ov8; o_z = z8; o_n = n8; o_c = c8; o_v = v8;
      o_il = il8; o_busy = busy8; o_res = {24'd0, res8}; o_tag = tag8;
    end else begin
      o_rdy = rdy32; o_valid = ov32; o_z = z32; o_n = n32; o_c = c32; o_v = v32;
      o_il = il32; o_busy = busy32; o_res = res32; o_tag = tag32;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    longint unsigned res;
    bit z, n, c, v, il;
    int lat;
  } exp_t;

  // Reference: plain wide arithmetic on the operation's definition.
  function automatic exp_t model(input int w, input logic [5:0] op,
                                 input longint unsigned a_in, input longint unsigned b_in);
    exp_t e;
    longint unsigned mask, a, b, full;
    longint sa, sb, sr, smax, smin;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sh = int'(b % longint'(w));
    sa = (((a >> (w - 1)) & 64'd1) != 0) ? $signed(a) - $signed(64'd1 << w) : $signed(a);
    sb = (((b >> (w - 1)) & 64'd1) != 0) ? $signed(b) - $signed(64'd1 << w) : $signed(b);
    smax = $signed((64'd1 << (w - 1)) - 64'd1);
    smin = -$signed(64'd1 << (w - 1));
    e = '{default: 0};
    case (op)
      OP_ADD: begin
        full = a + b; e.res = full & mask; e.c = ((full >> w) & 64'd1) != 0;
        sr = sa + sb; e.v = (sr > smax) || (sr < smin);
      end
      OP_SUB: begin
        e.res = (a - b) & mask; e.c = a < b;
        sr = sa - sb; e.v = (sr > smax) || (sr < smin);
      end
      OP_AND:   e.res = a & b;
      OP_OR:    e.res = a | b;
      OP_XOR:   e.res = a ^ b;
      OP_NOR:   e.res = ~(a | b) & mask;
      OP_SLL:   e.res = (a << sh) & mask;
      OP_SRL:   e.res = a >> sh;
      OP_SRA:   e.res = $unsigned(sa >>> sh) & mask;
      OP_MOV_A: e.res = a;
      OP_MOV_B: e.res = b;
      OP_MUL: begin
        full = a * b; e.res = full & mask; e.v = (full >> w) != 0; e.lat = w;
      end
      OP_DIV:    begin e.res = (b == 0) ? mask : a / b; e.lat = w; end
      OP_REMDER: begin e.res = (b == 0) ? mask : a % b; e.lat = w; end
      default:   begin e.res = 0; e.il = 1'b1; end
    endcase
    e.z = (e.res == 0);
    e.n = ((e.res >> (w - 1)) & 64'd1) != 0;
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t e, input logic [3:0] tag);
    check_eq({name, ".res"}, 64'(o_res), e.res);
    check_eq({name, ".zero"}, 64'(o_z), 64'(e.z));
    check_eq({name, ".neg"}, 64'(o_n), 64'(e.n));
    check_eq({name, ".carry"}, 64'(o_c), 64'(e.c));
    check_eq({name, ".ovf"}, 64'(o_v), 64'(e.v));
    check_eq({name, ".ill"}, 64'(o_il), 64'(e.il));
    check_eq({name, ".tag"}, 64'(o_tag), 64'(tag));
  endtask

  // Offer one op, wait for accept, then wait for the result and check
  // both its contents and its latency from the accept edge.
  task automatic run_op(input bit s8, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input string name);
    exp_t e;
    int n;
    e = model(s8 ? 8 : 32, op, 64'(a), 64'(b));
    @(negedge clk);
    sel8 = s8;
    in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    if (s8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
    n = 0;
    while (!o_rdy && n < 60) begin @(negedge clk); n++; end
    check_eq({name, ".in_ready"}, 64'(o_rdy), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_valid32 = 1'b0;
    if (e.lat > 0) check_eq({name, ".busy"}, 64'(o_busy), 64'd1);
    n = 0;
    while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
    check_eq({name, ".latency"}, 64'(n), 64'(e.lat));
    check_out(name, e, tag);
  endtask

  logic [5:0] single_ops [11] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
                                  OP_SLL, OP_SRL, OP_SRA, OP_MOV_A, OP_MOV_B};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 13) return 6'(r);
    if (r == 14) return 6'h3F;
    return 6'($urandom_range(14, 63));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [3:0] t;
    rst = 1'b1;
    in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    #12;
    check_eq("reset.out_valid", 64'(ov32), 64'd0);
    check_eq("reset.result", 64'(res32), 64'd0);
    check_eq("reset.busy", 64'(busy32), 64'd0);
    check_eq("reset.tag", 64'(tag32), 64'd0);
    check_eq("reset.in_ready", 64'(rdy32), 64'd1);
    check_eq("reset.out_valid8", 64'(ov8), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'h1, "add_wrap");
    run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'h2, "add_ovf");
    run_op(0, OP_SUB, 32'd3, 32'd5, 4'h3, "sub_borrow");
    run_op(0, OP_SRA, 32'h8000_0000, 32'd4, 4'h4, "sra");
    run_op(0, OP_SLL, 32'h0000_0003, 32'd33, 4'h5, "sll33");
    run_op(0, OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'h6, "mul_ovf");
    run_op(0, OP_DIV, 32'd100, 32'd7, 4'h7, "div");
    run_op(0, OP_REMDER, 32'd100, 32'd7, 4'h8, "rem");
    run_op(0, OP_DIV, 32'd5, 32'd0, 4'h9, "div0");
    run_op(0, OP_REMDER, 32'd5, 32'd0, 4'hA, "rem0");
    run_op(0, 6'h3F, 32'd12, 32'd34, 4'hB, "illegal");
    run_op(1, OP_MUL, 32'd16, 32'd16, 4'hC, "mul8");
    run_op(1, OP_ADD, 32'd127, 32'd1, 4'hD, "add8_ovf");

    // Reset during the 10th cycle of a divide.
    @(negedge clk);
    sel8 = 1'b0;
    in_op = OP_DIV; in_a = 32'd1000; in_b = 32'd3; in_tag = 4'h1; in_valid32 = 1'b1;
    @(posedge clk); #1; in_valid32 = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid.out_valid", 64'(ov32), 64'd0);
    check_eq("rst_mid.in_ready", 64'(rdy32), 64'd1);
    check_eq("rst_mid.busy", 64'(busy32), 64'd0);
    check_eq("rst_mid.result", 64'(res32), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(0, OP_ADD, 32'd1, 32'd1, 4'h2, "after_rst");

    // Backpressure: hold ADD result, XOR queued behind it.
    @(negedge clk);
    sel8 = 1'b0;
    in_op = OP_ADD; in_a = 32'd10; in_b = 32'd20; in_tag = 4'h3;
    in_valid32 = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_op = OP_XOR; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_4321; in_tag = 4'h9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp.valid", 64'(ov32), 64'd1);
      check_eq("bp.result", 64'(res32), 64'd30);
      check_eq("bp.tag", 64'(tag32), 64'h3);
      check_eq("bp.in_ready", 64'(rdy32), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; in_valid32 = 1'b0;
    check_eq("bp.xor_valid", 64'(ov32), 64'd1);
    check_out("bp.xor", model(32, OP_XOR, 64'h0F0F0_1234, 64'h0FF0_4321), 4'h9);

    // Back-to-back single-cycle ops: one result per clock.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_op = single_ops[$urandom_range(0, 10)];
      in_a = rand_operand(); in_b = rand_operand(); in_tag = 4'(i);
      e = model(32, in_op, 64'(in_a), 64'(in_b));
      check_eq("b2b.in_ready", 64'(rdy32), 64'd1);
      in_valid32 = 1'b1;
      @(posedge clk); #1;
      check_eq("b2b.valid", 64'(ov32), 64'd1);
      check_out("b2b", e, 4'(i));
    end
    @(negedge clk); in_valid32 = 1'b0;

    // Randomized mix on both widths.
    for (int i = 0; i < 40; i++) begin
      t = 4'($urandom);
      run_op(0, rand_op(), rand_operand(), rand_operand(), t, "rand32");
    end
    for (int i = 0; i < 20; i++) begin
      t = 4'($urandom);
      run_op(1, rand_op(), $urandom, 32'($urandom_range(0, 255)), t, "rand8");
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
